// File: rtl/dlx_mem_pkg.sv
// Shared types for the memory-access stage: FSM encoding and fault-cause codes.
package dlx_mem_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    localparam logic [1:0] FAULT_NONE  = 2'd0;
    localparam logic [1:0] FAULT_RDWR  = 2'd1;
    localparam logic [1:0] FAULT_ALIGN = 2'd2;
    localparam logic [1:0] FAULT_RANGE = 2'd3;

endpackage

// File: rtl/memory_access_pipe.sv
// MEM/WB pipeline register; a stall loads a bubble (write enable and error cleared, payload held).
module memory_access_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_stall,
    input  logic                      i_load_done,
    input  logic                      i_error,
    input  logic                      i_reg_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_reg_wr_addr,
    input  logic                      i_wb_sel,
    input  logic [DATA_WIDTH-1:0]     i_alu_data,
    input  logic [DATA_WIDTH-1:0]     i_rd_data,
    output logic [DATA_WIDTH-1:0]     o_mem_data,
    output logic [DATA_WIDTH-1:0]     o_alu_data,
    output logic                      o_reg_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] o_reg_wr_addr,
    output logic                      o_wb_sel,
    output logic                      o_error
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_mem_data    <= '0;
            o_alu_data    <= '0;
            o_reg_wr_en   <= 1'b0;
            o_reg_wr_addr <= '0;
            o_wb_sel      <= 1'b0;
            o_error       <= 1'b0;
        end else if (i_stall) begin
            o_reg_wr_en <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            o_alu_data    <= i_alu_data;
            o_reg_wr_en   <= i_reg_wr_en;
            o_reg_wr_addr <= i_reg_wr_addr;
            o_wb_sel      <= i_wb_sel;
            o_error       <= i_error;
            // Only a load that actually completes refreshes the load-data field.
            if (i_load_done)
                o_mem_data <= i_rd_data;
        end
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access stage: req/ack data-memory handshake with timeout abort, upstream stall and MEM/WB register.
//   state   | meaning
//   ST_IDLE | no access outstanding; a clean op issues its request combinationally
//   ST_WAIT | request outstanding, counting unacknowledged cycles toward abort
module memory_access
    import dlx_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_data_rd_en_in,
    input  logic                      mem_data_wr_en_in,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic [DATA_WIDTH-1:0]     alu_data_in,
    input  logic                      reg_wr_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
    input  logic                      write_back_mux_sel_in,
    output logic                      dmem_req_out,
    output logic                      dmem_wr_en_out,
    output logic [ADDR_WIDTH-1:0]     dmem_addr_out,
    output logic [DATA_WIDTH-1:0]     dmem_wr_data_out,
    input  logic                      dmem_ack_in,
    input  logic [DATA_WIDTH-1:0]     dmem_rd_data_in,
    output logic                      mem_stall_out,
    output logic [DATA_WIDTH-1:0]     mem_data_out,
    output logic [DATA_WIDTH-1:0]     alu_data_out,
    output logic                      reg_wr_en_out,
    output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
    output logic                      write_back_mux_sel_out,
    output logic                      mem_error_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic       w_mem_op;
    logic [1:0] w_fault_cause;
    logic       w_fault;
    logic       w_req;
    logic       w_at_limit;
    logic       w_abort;
    logic       w_stall;
    logic       w_load_done;
    logic       w_error;
    logic       w_wb_en;

    assign w_mem_op = mem_data_rd_en_in | mem_data_wr_en_in;

    always_comb begin
        w_fault_cause = FAULT_NONE;
        if (mem_data_rd_en_in & mem_data_wr_en_in)
            w_fault_cause = FAULT_RDWR;
        else if (w_mem_op & (alu_data_in[1:0] != 2'b00))
            w_fault_cause = FAULT_ALIGN;
        else if (w_mem_op & (|alu_data_in[DATA_WIDTH-1:ADDR_WIDTH+2]))
            w_fault_cause = FAULT_RANGE;
    end

    // Inputs are frozen during WAIT, so a fault can only be seen at issue time.
    assign w_fault     = (r_state == ST_IDLE) & (w_fault_cause != FAULT_NONE);
    assign w_req       = (r_state == ST_WAIT) | (w_mem_op & ~w_fault);
    assign w_at_limit  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_abort     = (r_state == ST_WAIT) & ~dmem_ack_in & w_at_limit;
    assign w_stall     = ~rst & w_req & ~dmem_ack_in & ~w_abort;
    assign w_load_done = w_req & dmem_ack_in & mem_data_rd_en_in;
    assign w_error     = w_fault | w_abort;
    assign w_wb_en     = reg_wr_en_in & ~w_error;

    assign dmem_req_out     = w_req & ~rst;
    assign dmem_wr_en_out   = mem_data_wr_en_in;
    assign dmem_addr_out    = alu_data_in[ADDR_WIDTH+1:2];
    assign dmem_wr_data_out = mem_data_in;
    assign mem_stall_out    = w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req & ~dmem_ack_in) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack_in | w_at_limit) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    memory_access_pipe #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_pipe (
        .clk           (clk),
        .rst           (rst),
        .i_stall       (w_stall),
        .i_load_done   (w_load_done),
        .i_error       (w_error),
        .i_reg_wr_en   (w_wb_en),
        .i_reg_wr_addr (reg_wr_addr_in),
        .i_wb_sel      (write_back_mux_sel_in),
        .i_alu_data    (alu_data_in),
        .i_rd_data     (dmem_rd_data_in),
        .o_mem_data    (mem_data_out),
        .o_alu_data    (alu_data_out),
        .o_reg_wr_en   (reg_wr_en_out),
        .o_reg_wr_addr (reg_wr_addr_out),
        .o_wb_sel      (write_back_mux_sel_out),
        .o_error       (mem_error_out)
    );

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed plan steps plus randomized ops against a transaction-level model.
module tb_memory_access;
    import dlx_mem_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int AW = 10;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_data_rd_en_in, mem_data_wr_en_in;
    logic [DW-1:0] mem_data_in, alu_data_in;
    logic          reg_wr_en_in;
    logic [RW-1:0] reg_wr_addr_in;
    logic          write_back_mux_sel_in;
    logic          dmem_req_out, dmem_wr_en_out;
    logic [AW-1:0] dmem_addr_out;
    logic [DW-1:0] dmem_wr_data_out;
    logic          dmem_ack_in;
    logic [DW-1:0] dmem_rd_data_in;
    logic          mem_stall_out;
    logic [DW-1:0] mem_data_out, alu_data_out;
    logic          reg_wr_en_out;
    logic [RW-1:0] reg_wr_addr_out;
    logic          write_back_mux_sel_out, mem_error_out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_md = '0;

    always #5 clk = ~clk;

    memory_access #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_data_rd_en_in(mem_data_rd_en_in), .mem_data_wr_en_in(mem_data_wr_en_in),
        .mem_data_in(mem_data_in), .alu_data_in(alu_data_in),
        .reg_wr_en_in(reg_wr_en_in), .reg_wr_addr_in(reg_wr_addr_in),
        .write_back_mux_sel_in(write_back_mux_sel_in),
        .dmem_req_out(dmem_req_out), .dmem_wr_en_out(dmem_wr_en_out),
        .dmem_addr_out(dmem_addr_out), .dmem_wr_data_out(dmem_wr_data_out),
        .dmem_ack_in(dmem_ack_in), .dmem_rd_data_in(dmem_rd_data_in),
        .mem_stall_out(mem_stall_out), .mem_data_out(mem_data_out), .alu_data_out(alu_data_out),
        .reg_wr_en_out(reg_wr_en_out), .reg_wr_addr_out(reg_wr_addr_out),
        .write_back_mux_sel_out(write_back_mux_sel_out), .mem_error_out(mem_error_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, "_req"},   32'(dmem_req_out), 32'd0);
        chk({tag, "_stall"}, 32'(mem_stall_out), 32'd0);
        chk({tag, "_md"},    mem_data_out, 32'd0);
        chk({tag, "_alu"},   alu_data_out, 32'd0);
        chk({tag, "_rwe"},   32'(reg_wr_en_out), 32'd0);
        chk({tag, "_rwa"},   32'(reg_wr_addr_out), 32'd0);
        chk({tag, "_wbs"},   32'(write_back_mux_sel_out), 32'd0);
        chk({tag, "_err"},   32'(mem_error_out), 32'd0);
    endtask

    // k = cycle (0 = issue cycle) in which ack arrives; k >= TO means the memory never answers.
    task automatic run_op(input string tag, input logic rd, input logic wr, input logic [31:0] alu,
                          input logic [31:0] wdata, input logic rwe, input logic [4:0] ra,
                          input logic wbs, input int k);
        bit mem_op, fault, issued, tmo;
        int last;
        logic [31:0] rdata;
        mem_op = rd || wr;
        fault  = (rd && wr) || (mem_op && (alu % 4) != 0) || (mem_op && alu >= (32'd1 << (AW + 2)));
        issued = mem_op && !fault;
        tmo    = issued && (k >= TO);
        last   = !issued ? 0 : (tmo ? TO - 1 : k);

        mem_data_rd_en_in = rd;  mem_data_wr_en_in = wr;
        alu_data_in = alu;       mem_data_in = wdata;
        reg_wr_en_in = rwe;      reg_wr_addr_in = ra;
        write_back_mux_sel_in = wbs;

        for (int c = 0; c <= last; c++) begin
            rdata = $urandom;
            dmem_rd_data_in = rdata;
            dmem_ack_in = issued ? (c == k) : 1'($urandom % 2);
            @(negedge clk);
            chk({tag, "_req"},   32'(dmem_req_out), 32'(issued));
            chk({tag, "_stall"}, 32'(mem_stall_out), 32'(c < last));
            if (issued) begin
                chk({tag, "_addr"},  32'(dmem_addr_out), (alu >> 2) & 32'h3FF);
                chk({tag, "_wren"},  32'(dmem_wr_en_out), 32'(wr));
                chk({tag, "_wdata"}, dmem_wr_data_out, wdata);
            end
            if (c == last && issued && !tmo && rd) exp_md = rdata;
            @(posedge clk);
            #1;
            if (c < last) begin
                chk({tag, "_bub_rwe"}, 32'(reg_wr_en_out), 32'd0);
                chk({tag, "_bub_err"}, 32'(mem_error_out), 32'd0);
            end else begin
                chk({tag, "_alu_o"}, alu_data_out, alu);
                chk({tag, "_rwa_o"}, 32'(reg_wr_addr_out), 32'(ra));
                chk({tag, "_wbs_o"}, 32'(write_back_mux_sel_out), 32'(wbs));
                chk({tag, "_rwe_o"}, 32'(reg_wr_en_out), 32'(rwe && !fault && !tmo));
                chk({tag, "_err_o"}, 32'(mem_error_out), 32'(fault || tmo));
                chk({tag, "_md_o"},  mem_data_out, exp_md);
            end
        end
        dmem_ack_in = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int kind, k;
        rst = 1'b1;
        mem_data_rd_en_in = 0; mem_data_wr_en_in = 0; mem_data_in = '0; alu_data_in = '0;
        reg_wr_en_in = 0; reg_wr_addr_in = '0; write_back_mux_sel_in = 0;
        dmem_ack_in = 0; dmem_rd_data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_regs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("nonmem",   0, 0, 32'h0000_1234, 32'h0, 1, 5'd7, 0, 0);
        run_op("ld0wait",  1, 0, 32'h0000_0010, 32'h0, 1, 5'd3, 1, 0);
        chk("ld0wait_data", mem_data_out, exp_md);
        run_op("st3wait",  0, 1, 32'h0000_0020, 32'hCAFE_0001, 0, 5'd0, 0, 3);
        run_op("ldtmo",    1, 0, 32'h0000_0004, 32'h0, 1, 5'd9, 1, 99);
        run_op("misalign", 1, 0, 32'h0000_0006, 32'h0, 1, 5'd4, 1, 0);
        run_op("rdwr",     1, 1, 32'h0000_0008, 32'h5, 1, 5'd4, 1, 0);
        run_op("range",    1, 0, 32'h0001_0000, 32'h0, 1, 5'd4, 1, 0);
        run_op("after_flt",1, 0, 32'h0000_0FFC, 32'h0, 1, 5'd31, 1, 2);

        // Reset in the second WAIT cycle of a load that is never acknowledged.
        mem_data_rd_en_in = 1; mem_data_wr_en_in = 0; alu_data_in = 32'h0000_0040;
        reg_wr_en_in = 1; reg_wr_addr_in = 5'd2; write_back_mux_sel_in = 1; dmem_ack_in = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_md = '0;
        chk_regs_zero("midrst");
        @(posedge clk); #1;
        mem_data_rd_en_in = 0; reg_wr_en_in = 0;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("post_rst", 1, 0, 32'h0000_0044, 32'h0, 1, 5'd6, 1, 0);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom % 8;
            k = $urandom % 5;
            a = {20'd0, 10'($urandom), 2'b00};
            case (kind)
                0, 1: run_op("r_nonmem", 0, 0, $urandom, $urandom, 1'($urandom), 5'($urandom), 1'($urandom), 0);
                2, 3: run_op("r_load", 1, 0, a, $urandom, 1'($urandom), 5'($urandom), 1'($urandom), k);
                4, 5: run_op("r_store", 0, 1, a, $urandom, 1'($urandom), 5'($urandom), 1'($urandom), k);
                6: begin
                    if ($urandom % 2 == 1) a[1:0] = 2'($urandom % 3 + 1);
                    else a[31:12] = 20'($urandom % 32'hFFFFF + 1);
                    run_op("r_fault", 1'($urandom), 1'($urandom), a, $urandom, 1, 5'($urandom), 1'($urandom), 0);
                end
                default: run_op("r_slow", 1, 0, a, $urandom, 1, 5'($urandom), 1, ($urandom % 4 == 0) ? 20 : int'($urandom % 8));
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
